// File: rtl/sonic_vc_arbiter_rr.sv
// Two-input, packet-granular round-robin merge for the SoNIC VC Avalon-ST path.
// The grant is held from SOP to EOP, and each registered output beat carries its source channel.
module sonic_vc_arbiter_rr #(
    parameter int DATA_WIDTH   = 128,
    parameter int BARDEC_WIDTH = 8,
    parameter int BE_WIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic                    in0_valid,
    output logic                    in0_ready,
    input  logic [DATA_WIDTH-1:0]   in0_data,
    input  logic                    in0_startofpacket,
    input  logic                    in0_endofpacket,
    input  logic                    in0_empty,
    input  logic [BARDEC_WIDTH-1:0] in0_bardec,
    input  logic [BE_WIDTH-1:0]     in0_be,

    input  logic                    in1_valid,
    output logic                    in1_ready,
    input  logic [DATA_WIDTH-1:0]   in1_data,
    input  logic                    in1_startofpacket,
    input  logic                    in1_endofpacket,
    input  logic                    in1_empty,
    input  logic [BARDEC_WIDTH-1:0] in1_bardec,
    input  logic [BE_WIDTH-1:0]     in1_be,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_startofpacket,
    output logic                    out_endofpacket,
    output logic                    out_empty,
    output logic [BARDEC_WIDTH-1:0] out_bardec,
    output logic [BE_WIDTH-1:0]     out_be,
    output logic                    out_channel,

    output logic                    proto_err,
    output logic [1:0]              state_dbg
);

    // Handshake: a beat moves on any rising edge where valid & ready are both high.
    // A source holds valid and payload until that happens. Ready never depends on
    // the source's own valid except through the IDLE grant choice.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last, last_nxt;
    logic   err_nxt;

    logic   accept;
    logic   gnt_valid;
    logic   gnt_sel;
    logic   xfer;

    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_sop;
    logic                    sel_eop;
    logic                    sel_empty;
    logic [BARDEC_WIDTH-1:0] sel_bardec;
    logic [BE_WIDTH-1:0]     sel_be;

    assign accept    = out_ready | ~out_valid;
    assign state_dbg = state;

    // In IDLE the grant goes to the lone requester. On a tie it goes to the input not served last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_sel   = 1'b0;
        case (state)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    gnt_valid = 1'b1;
                    gnt_sel   = ~last;
                end else if (in0_valid) begin
                    gnt_valid = 1'b1;
                    gnt_sel   = 1'b0;
                end else if (in1_valid) begin
                    gnt_valid = 1'b1;
                    gnt_sel   = 1'b1;
                end
            end
            LOCK0: begin
                gnt_valid = 1'b1;
                gnt_sel   = 1'b0;
            end
            LOCK1: begin
                gnt_valid = 1'b1;
                gnt_sel   = 1'b1;
            end
            default: ;
        endcase
    end

    assign in0_ready = accept & gnt_valid & ~gnt_sel;
    assign in1_ready = accept & gnt_valid &  gnt_sel;
    assign xfer      = (in0_valid & in0_ready) | (in1_valid & in1_ready);

    always_comb begin
        sel_data   = in0_data;
        sel_sop    = in0_startofpacket;
        sel_eop    = in0_endofpacket;
        sel_empty  = in0_empty;
        sel_bardec = in0_bardec;
        sel_be     = in0_be;
        if (gnt_sel) begin
            sel_data   = in1_data;
            sel_sop    = in1_startofpacket;
            sel_eop    = in1_endofpacket;
            sel_empty  = in1_empty;
            sel_bardec = in1_bardec;
            sel_be     = in1_be;
        end
    end

    // A headless beat accepted in IDLE still opens a packet, but it is flagged as a protocol error.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        err_nxt   = proto_err;
        case (state)
            IDLE: begin
                if (xfer) begin
                    last_nxt = gnt_sel;
                    if (!sel_sop) err_nxt = 1'b1;
                    if (!sel_eop) state_nxt = gnt_sel ? LOCK1 : LOCK0;
                end
            end
            LOCK0, LOCK1: begin
                if (xfer && sel_eop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            proto_err <= err_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_empty         <= 1'b0;
            out_bardec        <= '0;
            out_be            <= '0;
            out_channel       <= 1'b0;
        end else if (xfer) begin
            out_valid         <= 1'b1;
            out_data          <= sel_data;
            out_startofpacket <= sel_sop;
            out_endofpacket   <= sel_eop;
            out_empty         <= sel_empty;
            out_bardec        <= sel_bardec;
            out_be            <= sel_be;
            out_channel       <= gnt_sel;
        end else if (out_ready) begin
            out_valid         <= 1'b0;
        end
    end

endmodule

// File: doc/sonic_vc_arbiter_rr.md
# sonic_vc_arbiter_rr

Two-input, packet-granular round-robin arbiter and multiplexer for the SoNIC virtual-channel Avalon-ST path. It merges two 128-bit Avalon-ST streams (with bardec/byte-enable sideband) into one output stream, holding the grant from start-of-packet to end-of-packet so packets are never interleaved. It is the merge-side counterpart of the VC demultiplexer and shares the single downstream VC datapath between two requesters. The output is registered and tags each beat with the source channel.

## Interface
- DATA_WIDTH, 128, data beat width
- BARDEC_WIDTH, 8, BAR-decode sideband width
- BE_WIDTH, 16, byte-enable sideband width
- One clock; reset is asynchronous and active-low.
- clk  in  1  sole clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- inN_valid / inN_ready  in / out  1 / 1  handshake for input N (N = 0, 1)
- inN_data  in  DATA_WIDTH  beat data
- inN_startofpacket, inN_endofpacket, inN_empty  in  1 each  framing
- inN_bardec  in  BARDEC_WIDTH; inN_be  in  BE_WIDTH  sideband, passed through with the beat
- out_valid  out  1; out_ready  in  1  output handshake
- out_data, out_startofpacket, out_endofpacket, out_empty, out_bardec, out_be  out  widths as inputs
- out_channel  out  1  index of the input that sourced the current output beat
- proto_err  out  1  sticky: beat without SOP accepted while IDLE

## Operation
- Output stage: `accept = out_ready | ~out_valid`. A beat transfers from input N when inN_valid & inN_ready; inN_ready = accept & (N is granted).
- States: IDLE, LOCK0, LOCK1. Reset -> IDLE; `last` pointer resets to 1, so input 0 wins the first tie.
- IDLE: grant is combinational in the same cycle. Only one valid -> grant it; both valid -> grant ~last; none -> no grant, both readies 0.
- On a transferred beat in IDLE: `last` <= granted N. If endofpacket = 0, go to LOCKN. If endofpacket = 1 (single-beat packet), stay IDLE.
- LOCKN: only inN_ready can be asserted; the other input's ready is 0 regardless of its valid. A transferred beat with endofpacket = 1 returns to IDLE. SOP seen inside LOCKN is forwarded unchanged and the state does not change.
- A beat transferred in IDLE with startofpacket = 0 is treated as a packet start (same grant and lock rules), and proto_err is set to 1 until reset.
- Payload {data, empty, eop, sop, bardec, be} and out_channel are captured into the output register on transfer. out_valid <= 1 on transfer; otherwise out_valid <= 0 when out_ready is high; otherwise it holds.
- Output register contents are stable while out_valid & ~out_ready.

## Timing
- Reset values: out_valid 0, all out_* payload 0, out_channel 0, proto_err 0, state IDLE, last 1. inN_ready is combinational: during reset it reads 1 for an IDLE grant only if inN_valid is asserted; no transfer is captured while reset_n is low.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat/cycle with out_ready held high, including back-to-back packets from alternating inputs (no bubble at the EOP/SOP boundary).
- Backpressure: out_ready low with out_valid high -> both readies 0 next evaluation; no beat is lost or duplicated.
- Reset mid-packet: state returns to IDLE and the output beat is discarded. Upstream must restart from SOP.
- Simultaneous SOP on both inputs in IDLE: exactly one is granted per the `last` rule; the loser's valid and payload must be held by the source.

## Test plan
- Reset, then in0 and in1 each present a 3-beat packet in the same cycle, out_ready = 1 -> output carries in0 beats 0-2 with out_channel = 0, then in1 beats 0-2 with out_channel = 1. Six consecutive valid cycles starting 1 cycle after the first accept; in1_ready = 0 for the first 3 cycles.
- Both inputs continuously offer 1-beat packets (sop = eop = 1) -> out_channel alternates 0, 1, 0, 1; 1 beat/cycle.
- 4-beat packet on in0 with out_ready toggling 1, 0, 0, 1, ... -> output beats are in order and stable while stalled; in0_ready tracks accept; in1 stays blocked until EOP is accepted.
- In IDLE, in1 sends a beat with sop = 0, eop = 1, data 0xA5 -> beat forwarded with out_channel = 1; proto_err = 1 and stays high afterwards.
- reset_n asserted low mid-way through a 5-beat in0 packet -> out_valid = 0 immediately. After release, an in1 SOP is granted at once (state IDLE) and last = 1 restored.
- Sideband check: in0_bardec = 0x5A, in0_be = 0xF00F -> out_bardec = 0x5A, out_be = 0xF00F on the same beat.
